switch_input_port: RTL and testbench

Memory-mapped switch input peripheral: synchronises and debounces a parametrised bank of slide switches plus a confirmation button, and latches a switch snapshot on each confirmed press. The CPU reads the data in one of several extract/extend formats through address decode. A status register reports whether a fresh snapshot is pending. It sits on the IO side of the MMIO bus, driving the load-data path when the switch select from the decoder is high.

---
 rtl/switch_input_port.sv | 170 +++++++++++++++++
 tb/tb_switch_input_port.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_input_port.sv
// switch_input_port
// Memory-mapped slide-switch and confirmation-button input peripheral.
// Each raw input is synchronised through two flops. It is then debounced
// with its own counter. A rising edge of the debounced button latches a
// snapshot of the debounced switches and raises "pending". The CPU reads
// the data in several extract/extend formats through address decode.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   switch_ctrl   read select from the MMIO decoder
//   address       bus address (mode k at BASE_ADDR + 2*k)
//   switch_input  raw asynchronous switch levels
//   confirmation  raw asynchronous active-high button
//   data_io_input registered read data (holds when not read)
//   pending       snapshot taken but not yet acknowledged by a status read
module switch_input_port #(
  parameter int          SW_WIDTH   = 16,
  parameter int          DATA_WIDTH = 32,
  parameter int          DB_CYCLES  = 20000,
  parameter int          LOW_BITS   = 3,
  parameter logic [31:0] BASE_ADDR  = 32'hffff_fff1,
  parameter int          LATCH_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  switch_ctrl,
  input  logic [31:0]           address,
  input  logic [SW_WIDTH-1:0]   switch_input,
  input  logic                  confirmation,
  output logic [DATA_WIDTH-1:0] data_io_input,
  output logic                  pending
);

  // Bit SW_WIDTH of the synchronised/debounced vectors carries the button.
  localparam int NB = SW_WIDTH + 1;
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  localparam logic [31:0] ADDR_ZX   = BASE_ADDR;
  localparam logic [31:0] ADDR_HI_S = BASE_ADDR + 32'd2;
  localparam logic [31:0] ADDR_HI_Z = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_LO8  = BASE_ADDR + 32'd6;
  localparam logic [31:0] ADDR_LOW  = BASE_ADDR + 32'd8;
  localparam logic [31:0] ADDR_STAT = BASE_ADDR + 32'd10;

  logic [NB-1:0]         sync1_q, sync1_d;
  logic [NB-1:0]         sync2_q, sync2_d;
  logic [NB-1:0]         stable_q, stable_d;
  logic [CNT_W-1:0]      cnt_q [NB];
  logic [CNT_W-1:0]      cnt_d [NB];
  logic                  btn_prev_q, btn_prev_d;
  logic [SW_WIDTH-1:0]   snapshot_q, snapshot_d;
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  strobe;
  logic                  status_rd;
  logic [SW_WIDTH-1:0]   src;
  logic [7:0]            hi_byte;

  // Two-flop synchroniser for every raw input, button included.
  always_comb begin
    sync1_d = {confirmation, switch_input};
    sync2_d = sync1_q;
  end

  // Per-bit debounce. The counter only runs while the synchronised bit
  // disagrees with the stable bit. Any agreement restarts it, so a glitch
  // shorter than DB_CYCLES never reaches the stable bit.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]    = '0;
        stable_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Confirmation edge detect, snapshot capture and read decode.
  // A strobe in the same cycle as a status read wins. The read still
  // returns the old pending value.
  always_comb begin
    strobe     = stable_q[SW_WIDTH] & ~btn_prev_q;
    btn_prev_d = stable_q[SW_WIDTH];
    snapshot_d = strobe ? stable_q[SW_WIDTH-1:0] : snapshot_q;

    src       = (LATCH_MODE != 0) ? snapshot_q : stable_q[SW_WIDTH-1:0];
    hi_byte   = src[SW_WIDTH-1 -: 8];
    status_rd = 1'b0;
    data_d    = data_q;

    if (switch_ctrl) begin
      case (address)
        ADDR_ZX: begin
          data_d = '0;
          data_d[SW_WIDTH-1:0] = src;
        end
        ADDR_HI_S: begin
          data_d = {DATA_WIDTH{hi_byte[7]}};
          data_d[7:0] = hi_byte;
        end
        ADDR_HI_Z: begin
          data_d = '0;
          data_d[7:0] = hi_byte;
        end
        ADDR_LO8: begin
          data_d = '0;
          data_d[7:0] = src[7:0];
        end
        ADDR_LOW: begin
          data_d = '0;
          data_d[LOW_BITS-1:0] = src[LOW_BITS-1:0];
        end
        ADDR_STAT: begin
          data_d = '0;
          data_d[0] = pending_q;
          status_rd = 1'b1;
        end
        default: data_d = data_q;
      endcase
    end

    if (strobe) begin
      pending_d = 1'b1;
    end else if (status_rd) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // State register. Reset clears everything, so debounce restarts from
  // the current input once reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      btn_prev_q <= 1'b0;
      snapshot_q <= '0;
      pending_q  <= 1'b0;
      data_q     <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      stable_q   <= stable_d;
      btn_prev_q <= btn_prev_d;
      snapshot_q <= snapshot_d;
      pending_q  <= pending_d;
      data_q     <= data_d;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign data_io_input = data_q;
  assign pending       = pending_q;

endmodule

// File: tb/tb_switch_input_port.sv
// Testbench for switch_input_port (DB_CYCLES = 4, other parameters default).
// A reference model runs at every clock edge. For each issued read, it
// pushes the expected read data into a scoreboard queue. A separate monitor
// pops the queue and compares it with the DUT one step after the edge. The
// model debounces with a sliding window over the raw input history: a bit
// takes a new value once the window holds DB_CYCLES equal samples.
module tb_switch_input_port;

  localparam int          SW   = 16;
  localparam int          DW   = 32;
  localparam int          DB   = 4;
  localparam int          LB   = 3;
  localparam logic [31:0] BASE = 32'hffff_fff1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          switch_ctrl = 1'b0;
  logic [31:0]   address = 32'h0;
  logic [SW-1:0] switch_input = 16'hffff;
  logic          confirmation = 1'b0;
  logic [DW-1:0] data_io_input;
  logic          pending;

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] cur_sw = 16'hffff;
  logic          cur_btn = 1'b0;

  logic [31:0] exp_q[$];

  logic [SW:0]   hist[$];
  logic [SW:0]   m_stable = '0;
  logic          m_prev = 1'b0;
  logic [SW-1:0] m_snap = '0;
  logic          m_pend = 1'b0;
  logic [31:0]   m_data = '0;

  always #5 clk = ~clk;

  switch_input_port #(
    .SW_WIDTH(SW), .DATA_WIDTH(DW), .DB_CYCLES(DB), .LOW_BITS(LB),
    .BASE_ADDR(BASE), .LATCH_MODE(1)
  ) dut (
    .clk(clk), .rst(rst), .switch_ctrl(switch_ctrl), .address(address),
    .switch_input(switch_input), .confirmation(confirmation),
    .data_io_input(data_io_input), .pending(pending)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] modeValue(input int k, input logic [SW-1:0] s,
                                            input logic p, input logic [31:0] old);
    case (k)
      0: return {16'h0, s};
      1: return {{24{s[15]}}, s[15:8]};
      2: return {24'h0, s[15:8]};
      3: return {24'h0, s[7:0]};
      4: return {29'h0, s[LB-1:0]};
      5: return {31'h0, p};
      default: return old;
    endcase
  endfunction

  // Reference model: it sees the same inputs the DUT samples on each edge.
  always @(posedge clk) begin : ref_model
    logic [SW:0] raw;
    logic        strobe;
    logic        status;
    logic        uniform;
    logic [31:0] off;
    int          k;
    raw = {confirmation, switch_input};
    if (rst) begin
      hist.delete();
      for (int i = 0; i < DB + 2; i++) hist.push_back('0);
      m_stable = '0;
      m_prev   = 1'b0;
      m_snap   = '0;
      m_pend   = 1'b0;
      m_data   = '0;
    end else begin
      strobe = m_stable[SW] && !m_prev;
      status = 1'b0;
      if (switch_ctrl) begin
        off = address - BASE;
        k = (off[0] == 1'b0 && off <= 32'd10) ? int'(off >> 1) : -1;
        m_data = modeValue(k, m_snap, m_pend, m_data);
        status = (k == 5);
        exp_q.push_back(m_data);
      end
      if (strobe) begin
        m_pend = 1'b1;
        m_snap = m_stable[SW-1:0];
      end else if (status) begin
        m_pend = 1'b0;
      end
      m_prev = m_stable[SW];
      hist.push_back(raw);
      void'(hist.pop_front());
      for (int b = 0; b <= SW; b++) begin
        uniform = 1'b1;
        for (int i = 1; i < DB; i++) if (hist[i][b] != hist[0][b]) uniform = 1'b0;
        if (uniform) m_stable[b] = hist[0][b];
      end
    end
  end

  // Monitor: a sampled select is the DUT's "output valid" for read data.
  initial begin : monitor
    logic        was_rd;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      was_rd = !rst && switch_ctrl;
      #1;
      if (was_rd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL read_data: got %h, expected nothing queued", data_io_input);
        end else begin
          e = exp_q.pop_front();
          checkOutput("read_data", data_io_input, e);
        end
      end
      checkOutput("pending", {31'h0, pending}, {31'h0, m_pend});
    end
  end

  task automatic applyStimulus(input logic r, input logic [SW-1:0] sw, input logic btn,
                               input logic ctrl, input logic [31:0] addr);
    @(negedge clk);
    rst          = r;
    switch_input = sw;
    confirmation = btn;
    switch_ctrl  = ctrl;
    address      = addr;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, cur_sw, cur_btn, 1'b0, 32'h0);
  endtask

  task automatic setInputs(input logic [SW-1:0] sw, input logic btn);
    cur_sw  = sw;
    cur_btn = btn;
    applyStimulus(1'b0, cur_sw, cur_btn, 1'b0, 32'h0);
  endtask

  task automatic doRead(input logic [31:0] addr);
    applyStimulus(1'b0, cur_sw, cur_btn, 1'b1, addr);
    applyStimulus(1'b0, cur_sw, cur_btn, 1'b0, 32'h0);
  endtask

  task automatic waitPending(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b0, cur_sw, cur_btn, 1'b0, 32'h0);
      if (pending) begin
        cyc = k;
        break;
      end
    end
  endtask

  initial begin : stimulus
    int cyc;
    logic r;
    logic ctrl;
    logic [31:0] addr;

    // Reset with all switches high.
    applyStimulus(1'b1, 16'hffff, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 16'hffff, 1'b0, 1'b0, 32'h0);
    checkOutput("reset_data", data_io_input, 32'h0);
    checkOutput("reset_pending", {31'h0, pending}, 32'h0);
    applyStimulus(1'b0, 16'hffff, 1'b0, 1'b1, BASE);
    applyStimulus(1'b0, 16'hffff, 1'b0, 1'b0, 32'h0);
    checkOutput("read_after_reset", data_io_input, 32'h0);
    setInputs(16'h0000, 1'b0);
    idle(10);

    // Short glitches on switch bit 0 and on the button.
    setInputs(16'h0001, 1'b1);
    idle(2);
    setInputs(16'h0000, 1'b0);
    idle(8);
    checkOutput("btn_glitch_pending", {31'h0, pending}, 32'h0);

    // Full press: the strobe sees the switch glitch as never having happened.
    setInputs(16'h0000, 1'b1);
    waitPending(cyc);
    checkOutput("press_latency", 32'(cyc), 32'd7);
    setInputs(16'h0000, 1'b0);
    idle(8);
    doRead(BASE);
    checkOutput("sw_glitch_filtered", data_io_input, 32'h0);
    doRead(BASE + 32'd10);
    checkOutput("status_read", data_io_input, 32'h1);
    checkOutput("status_cleared", {31'h0, pending}, 32'h0);

    // Switch bit 0 stable exactly 2+DB cycles after it rises.
    setInputs(16'h0001, 1'b1);
    waitPending(cyc);
    setInputs(16'h0000, 1'b1);
    doRead(BASE);
    checkOutput("sw_stable_in_time", data_io_input, 32'h1);
    doRead(BASE + 32'd10);
    setInputs(16'h0000, 1'b0);
    idle(8);
    setInputs(16'h0000, 1'b1);
    setInputs(16'h0001, 1'b1);
    waitPending(cyc);
    checkOutput("press_latency_late_sw", 32'(cyc), 32'd6);
    doRead(BASE);
    checkOutput("sw_not_yet_stable", data_io_input, 32'h0);
    doRead(BASE + 32'd10);
    setInputs(16'h0000, 1'b0);
    idle(8);

    // Snapshot and read formats.
    setInputs(16'h8A35, 1'b0);
    idle(8);
    setInputs(16'h8A35, 1'b1);
    waitPending(cyc);
    checkOutput("snapshot_pending", {31'h0, pending}, 32'h1);
    setInputs(16'h0000, 1'b1);
    idle(8);
    doRead(BASE);
    checkOutput("fmt_zx", data_io_input, 32'h0000_8A35);
    doRead(BASE + 32'd2);
    checkOutput("fmt_hi_sext", data_io_input, 32'hFFFF_FF8A);
    doRead(BASE + 32'd4);
    checkOutput("fmt_hi_zext", data_io_input, 32'h0000_008A);
    doRead(BASE + 32'd6);
    checkOutput("fmt_lo8", data_io_input, 32'h0000_0035);
    doRead(BASE + 32'd8);
    checkOutput("fmt_low", data_io_input, 32'h0000_0005);
    doRead(BASE + 32'd1);
    checkOutput("unmapped_hold", data_io_input, 32'h0000_0005);
    doRead(BASE + 32'd12);
    checkOutput("unmapped_hold2", data_io_input, 32'h0000_0005);

    // Status read, then a status read coinciding with a new strobe.
    doRead(BASE + 32'd10);
    checkOutput("status_one", data_io_input, 32'h1);
    checkOutput("status_clear", {31'h0, pending}, 32'h0);
    setInputs(16'h1234, 1'b0);
    idle(8);
    setInputs(16'h1234, 1'b1);
    idle(5);
    applyStimulus(1'b0, cur_sw, cur_btn, 1'b1, BASE + 32'd10);
    applyStimulus(1'b0, cur_sw, cur_btn, 1'b0, 32'h0);
    checkOutput("coincide_read", data_io_input, 32'h0);
    checkOutput("coincide_pending", {31'h0, pending}, 32'h1);
    doRead(BASE);
    checkOutput("coincide_snapshot", data_io_input, 32'h0000_1234);

    // Reset in the middle of the button's debounce window.
    setInputs(16'h1234, 1'b0);
    doRead(BASE + 32'd10);
    idle(8);
    setInputs(16'h1234, 1'b1);
    idle(4);
    applyStimulus(1'b1, cur_sw, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, cur_sw, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, cur_sw, 1'b1, 1'b0, 32'h0);
    checkOutput("midpress_reset_pending", {31'h0, pending}, 32'h0);
    checkOutput("midpress_reset_data", data_io_input, 32'h0);
    waitPending(cyc);
    checkOutput("press_after_reset", 32'(cyc), 32'd7);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) == 0) cur_sw = 16'($urandom);
      if ($urandom_range(0, 6) == 0) cur_btn = ~cur_btn;
      r    = ($urandom_range(0, 199) == 0);
      ctrl = ($urandom_range(0, 2) == 0);
      addr = ($urandom_range(0, 9) == 0) ? BASE + 32'd1
                                         : BASE + 32'(2 * $urandom_range(0, 7));
      applyStimulus(r, cur_sw, cur_btn, ctrl, addr);
    end
    applyStimulus(1'b0, cur_sw, cur_btn, 1'b0, 32'h0);
    idle(3);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
